// File: rtl/handshake_checker_if.sv
// Request/response handshake bundle observed by handshake_checker.
//
// Signals:
//   valid, ready  request channel handshake
//   data          request payload, data_width bits
//   resp_valid,   response channel handshake
//   resp_ready
//
// Modports:
//   master  drives every signal (traffic source / bench side)
//   slave   samples every signal; the checker is a passive observer
interface handshake_checker_if #(
  parameter int unsigned data_width = 32
) ();

  logic                  valid;
  logic                  ready;
  logic [data_width-1:0] data;
  logic                  resp_valid;
  logic                  resp_ready;

  modport master (
    output valid,
    output ready,
    output data,
    output resp_valid,
    output resp_ready
  );

  modport slave (
    input valid,
    input ready,
    input data,
    input resp_valid,
    input resp_ready
  );

endinterface

// File: rtl/handshake_checker.sv
// Protocol checker for one valid/ready request channel and its paired
// response channel. It flags handshake-rule violations, latches the code of
// the first one, and counts completed requests and outstanding requests.
//
// Ports:
//   clock        sole clock, rising-edge sampling
//   reset        asynchronous active-high reset, clears all state
//   bus          handshake_checker_if.slave: valid, ready, data,
//                resp_valid, resp_ready
//   error        sticky violation flag
//   error_code   first violation: 1 valid drop, 2 data change, 3 timeout,
//                4 response underflow, 5 outstanding overflow; 0 = none
//   txn_count    completed request handshakes, wraps at 16 bits
//   outstanding  accepted requests still awaiting a response
//
// Parameters: timeout must be >= 2, max_outstanding must be >= 1.
module handshake_checker #(
  parameter int unsigned data_width      = 32,
  parameter int unsigned timeout         = 256,
  parameter int unsigned max_outstanding = 4,
  localparam int unsigned out_width      = $clog2(max_outstanding + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  handshake_checker_if.slave     bus,
  output logic                   error,
  output logic [2:0]             error_code,
  output logic [15:0]            txn_count,
  output logic [out_width-1:0]   outstanding
);

  // The stall counter only has to reach timeout-1.
  localparam int unsigned stall_width = $clog2(timeout);
  localparam logic [stall_width-1:0] stall_max = stall_width'(timeout - 1);
  localparam logic [out_width-1:0]   out_max   = out_width'(max_outstanding);

  typedef enum logic [1:0] {
    StIdle,
    StStall,
    StErr
  } state_e;

  state_e                 state_q, state_d;
  logic                   error_q, error_d;
  logic [2:0]             code_q, code_d;
  logic [15:0]            txn_q, txn_d;
  logic [out_width-1:0]   out_q, out_d;
  logic [stall_width-1:0] stall_cnt_q, stall_cnt_d;

  // Previous-edge samples.
  logic                   valid_p, ready_p;
  logic [data_width-1:0]  data_p;

  logic       req_hs, resp_hs, stall_now, stalled_p;
  logic       v_drop, v_data, v_timeout, v_under, v_over;
  logic [2:0] viol_code;

  assign req_hs    = bus.valid & bus.ready;
  assign resp_hs   = bus.resp_valid & bus.resp_ready;
  assign stall_now = bus.valid & ~bus.ready;
  assign stalled_p = valid_p & ~ready_p;

  assign v_drop    = stalled_p & ~bus.valid;
  assign v_data    = stalled_p & bus.valid & (bus.data != data_p);
  assign v_timeout = stall_now & (stall_cnt_q == stall_max);
  assign v_under   = resp_hs & ~req_hs & (out_q == '0);
  assign v_over    = req_hs & ~resp_hs & (out_q == out_max);

  // Lowest code wins when several rules fire on the same edge.
  always_comb begin
    viol_code = 3'd0;
    if (v_drop) begin
      viol_code = 3'd1;
    end else if (v_data) begin
      viol_code = 3'd2;
    end else if (v_timeout) begin
      viol_code = 3'd3;
    end else if (v_under) begin
      viol_code = 3'd4;
    end else if (v_over) begin
      viol_code = 3'd5;
    end
  end

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    code_d  = code_q;

    case (state_q)
      StIdle:  if (stall_now) state_d = StStall;
      StStall: if (req_hs || !bus.valid) state_d = StIdle;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase

    // ERR is terminal and freezes the code of the first violation.
    if (state_q != StErr && viol_code != 3'd0) begin
      state_d = StErr;
      error_d = 1'b1;
      code_d  = viol_code;
    end
  end

  // Counters keep running in ERR.
  always_comb begin
    txn_d = txn_q + 16'(req_hs);

    stall_cnt_d = '0;
    if (stall_now) begin
      stall_cnt_d = (stall_cnt_q == stall_max) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end

    // Underflow/overflow leave the count unchanged, keeping it in range.
    out_d = out_q;
    if (req_hs && !resp_hs && out_q != out_max) begin
      out_d = out_q + 1'b1;
    end else if (resp_hs && !req_hs && out_q != '0) begin
      out_d = out_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      error_q     <= 1'b0;
      code_q      <= 3'd0;
      txn_q       <= '0;
      out_q       <= '0;
      stall_cnt_q <= '0;
      valid_p     <= 1'b0;
      ready_p     <= 1'b0;
      data_p      <= '0;
    end else begin
      state_q     <= state_d;
      error_q     <= error_d;
      code_q      <= code_d;
      txn_q       <= txn_d;
      out_q       <= out_d;
      stall_cnt_q <= stall_cnt_d;
      valid_p     <= bus.valid;
      ready_p     <= bus.ready;
      data_p      <= bus.data;
    end
  end

  assign error       = error_q;
  assign error_code  = code_q;
  assign txn_count   = txn_q;
  assign outstanding = out_q;

endmodule

// File: tb/tb_handshake_checker.sv
// Bench for handshake_checker: directed scenarios plus random traffic, with
// every output compared each cycle against a behavioural model.
module tb_handshake_checker;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
  localparam int unsigned MO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        error;
  logic [2:0]  error_code;
  logic [15:0] txn_count;
  logic [2:0]  outstanding;

  handshake_checker_if #(.data_width(DW)) bus ();

  handshake_checker #(
    .data_width      (DW),
    .timeout         (TO),
    .max_outstanding (MO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .error       (error),
    .error_code  (error_code),
    .txn_count   (txn_count),
    .outstanding (outstanding)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_err    = 1'b0;
  int          m_code   = 0;
  int          m_txn    = 0;
  int          m_out    = 0;
  int          m_run    = 0;      // consecutive stalled samples before this edge
  bit          m_pstall = 1'b0;   // previous sample was a stall
  logic [31:0] m_pdata  = '0;

  function automatic int model_violation(bit v, bit r, logic [31:0] d, bit rs);
    bit       req;
    bit [5:1] f;
    req  = v && r;
    f[1] = m_pstall && !v;
    f[2] = m_pstall && v && (d != m_pdata);
    f[3] = v && !r && (m_run >= int'(TO) - 1);
    f[4] = rs && !req && (m_out == 0);
    f[5] = req && !rs && (m_out == int'(MO));
    for (int c = 1; c <= 5; c++) begin
      if (f[c]) return c;
    end
    return 0;
  endfunction

  function automatic int model_next_out(bit req, bit rs);
    if (req && !rs) return (m_out < int'(MO)) ? m_out + 1 : m_out;
    if (rs && !req) return (m_out > 0) ? m_out - 1 : m_out;
    return m_out;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_err    <= 1'b0;
      m_code   <= 0;
      m_txn    <= 0;
      m_out    <= 0;
      m_run    <= 0;
      m_pstall <= 1'b0;
      m_pdata  <= '0;
    end else begin
      if (!m_err && model_violation(bus.valid, bus.ready, bus.data,
                                    bus.resp_valid && bus.resp_ready) != 0) begin
        m_err  <= 1'b1;
        m_code <= model_violation(bus.valid, bus.ready, bus.data,
                                  bus.resp_valid && bus.resp_ready);
      end
      if (bus.valid && bus.ready) m_txn <= (m_txn + 1) % 65536;
      m_out    <= model_next_out(bus.valid && bus.ready, bus.resp_valid && bus.resp_ready);
      m_run    <= (bus.valid && !bus.ready) ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      m_pstall <= bus.valid && !bus.ready;
      m_pdata  <= bus.data;
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      check("error", int'(error), int'(m_err));
      check("error_code", int'(error_code), m_code);
      check("txn_count", int'(txn_count), m_txn);
      check("outstanding", int'(outstanding), m_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input bit r, input logic [31:0] d,
                     input bit rv, input bit rr);
    bus.valid      = v;
    bus.ready      = r;
    bus.data       = d;
    bus.resp_valid = rv;
    bus.resp_ready = rr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid      = 1'b0;
    bus.ready      = 1'b0;
    bus.data       = '0;
    bus.resp_valid = 1'b0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    idle_inputs();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset values
    check("reset error", int'(error), 0);
    check("reset error_code", int'(error_code), 0);
    check("reset txn_count", int'(txn_count), 0);
    check("reset outstanding", int'(outstanding), 0);

    // Clean traffic: one stall cycle, handshake, response two edges later
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 32'h100 + i, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 32'h100 + i, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    check("clean error", int'(error), 0);
    check("clean txn_count", int'(txn_count), 10);
    check("clean outstanding", int'(outstanding), 0);

    // Valid drop, then a later data change must not alter the code
    do_reset();
    cyc(1'b1, 1'b0, 32'h7, 1'b0, 1'b0);
    check("drop pre error", int'(error), 0);
    cyc(1'b0, 1'b0, 32'h7, 1'b0, 1'b0);
    check("drop error", int'(error), 1);
    check("drop code", int'(error_code), 1);
    cyc(1'b1, 1'b0, 32'hA5, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h5A, 1'b0, 1'b0);
    check("drop code frozen", int'(error_code), 1);

    // Data change during a stall
    do_reset();
    cyc(1'b1, 1'b0, 32'hA5, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h5A, 1'b0, 1'b0);
    check("data change code", int'(error_code), 2);
    check("model data change code", m_code, 2);

    // Timeout: flagged on the 4th stalled edge, not the 3rd
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
    check("timeout 3rd edge error", int'(error), 0);
    cyc(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
    check("timeout code", int'(error_code), 3);

    // Overflow: 5 requests with no response
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i, 1'b0, 1'b0);
    check("ovf pre error", int'(error), 0);
    check("ovf pre outstanding", int'(outstanding), 4);
    cyc(1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
    check("ovf code", int'(error_code), 5);
    check("ovf outstanding", int'(outstanding), 4);
    check("ovf txn_count", int'(txn_count), 5);

    // Simultaneous request and response at the limit
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h9, 1'b1, 1'b1);
    check("simul error", int'(error), 0);
    check("simul outstanding", int'(outstanding), 4);
    check("model simul outstanding", m_out, 4);

    // Underflow right after reset
    do_reset();
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("unf code", int'(error_code), 4);
    check("unf outstanding", int'(outstanding), 0);

    // txn_count wrap
    do_reset();
    repeat (65535) cyc(1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
    check("wrap pre txn_count", int'(txn_count), 65535);
    cyc(1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
    check("wrap txn_count", int'(txn_count), 0);
    check("wrap error", int'(error), 0);

    // Asynchronous reset mid-stall with two outstanding
    do_reset();
    cyc(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
    check("mid pre outstanding", int'(outstanding), 2);
    #2;
    reset = 1'b1;
    #1;
    check("mid reset txn_count", int'(txn_count), 0);
    check("mid reset outstanding", int'(outstanding), 0);
    check("mid reset error", int'(error), 0);
    check("mid reset error_code", int'(error_code), 0);
    bus.valid = 1'b0;
    #2;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 32'h3, 1'b0, 1'b0);
    check("post reset error", int'(error), 0);
    check("post reset error_code", int'(error_code), 0);

    // Random traffic
    do_reset();
    rd = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if (m_err && ($urandom_range(0, 5) == 0)) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) rd = $urandom_range(0, 3);
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rd,
            $urandom_range(0, 4) < 2, $urandom_range(0, 4) < 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
